fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the LEGv8 core. It owns the program counter and issues one word fetch at a time to instruction memory over a valid/ready request and variable-latency response channel. It delivers the fetched instruction, its PC and the 11-bit opcode field to the decode stage, where the opcode drives the control unit. It honours decode stalls and branch redirects from later stages.

---
 rtl/fetch_stage.sv | 144 ++++++++++++++
 tb/tb_fetch_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// LEGv8 instruction fetch + IF/ID register: one outstanding word fetch, 2-cycle best-case issue-to-decode.
// Decode stall holds IF/ID and parks a returning word in a skid register; redirect flushes everything.
module fetch_stage #(
  parameter int                   PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_rsp_valid,
  input  logic [31:0]         imem_rsp_data,
  output logic                if_id_valid,
  output logic [PC_WIDTH-1:0] if_id_pc,
  output logic [31:0]         if_id_instr,
  output logic [10:0]         opcode
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] pc, pc_nxt;
  logic                drop, drop_nxt;
  logic [31:0]         skid_instr, skid_instr_nxt;
  logic [PC_WIDTH-1:0] skid_pc, skid_pc_nxt;
  logic                if_id_valid_nxt;
  logic [PC_WIDTH-1:0] if_id_pc_nxt;
  logic [31:0]         if_id_instr_nxt;
  logic                load;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] redirect_target;

  assign pc_inc          = pc + PC_WIDTH'(4);
  assign redirect_target = redirect_pc & ~PC_WIDTH'(3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      drop        <= 1'b0;
      skid_instr  <= '0;
      skid_pc     <= '0;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      drop        <= drop_nxt;
      skid_instr  <= skid_instr_nxt;
      skid_pc     <= skid_pc_nxt;
      if_id_valid <= if_id_valid_nxt;
      if_id_pc    <= if_id_pc_nxt;
      if_id_instr <= if_id_instr_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    drop_nxt        = drop;
    skid_instr_nxt  = skid_instr;
    skid_pc_nxt     = skid_pc;
    if_id_pc_nxt    = if_id_pc;
    if_id_instr_nxt = if_id_instr;
    load            = 1'b0;

    case (state)
      S_REQ: begin
        if (imem_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (drop) begin
            drop_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else if (!(if_id_valid && stall)) begin
            load            = 1'b1;
            if_id_instr_nxt = imem_rsp_data;
            if_id_pc_nxt    = pc;
            pc_nxt          = pc_inc;
            state_nxt       = S_REQ;
          end else begin
            skid_instr_nxt = imem_rsp_data;
            skid_pc_nxt    = pc;
            state_nxt      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          load            = 1'b1;
          if_id_instr_nxt = skid_instr;
          if_id_pc_nxt    = skid_pc;
          pc_nxt          = pc_inc;
          state_nxt       = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase

    if (load)        if_id_valid_nxt = 1'b1;
    else if (!stall) if_id_valid_nxt = 1'b0;
    else             if_id_valid_nxt = if_id_valid;

    // Redirect wins over stall; an already-accepted fetch must still be drained via drop.
    if (redirect_valid) begin
      pc_nxt          = redirect_target;
      if_id_valid_nxt = 1'b0;
      if_id_pc_nxt    = if_id_pc;
      if_id_instr_nxt = if_id_instr;
      skid_instr_nxt  = skid_instr;
      skid_pc_nxt     = skid_pc;
      drop_nxt        = drop;
      state_nxt       = S_REQ;
      case (state)
        S_REQ: begin
          if (imem_req_ready) begin
            state_nxt = S_WAIT;
            drop_nxt  = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            drop_nxt = 1'b0;
          end else begin
            state_nxt = S_WAIT;
            drop_nxt  = 1'b1;
          end
        end
        default: state_nxt = S_REQ;
      endcase
    end
  end

  assign imem_req_valid = rst_n && (state == S_REQ);
  assign imem_addr      = pc;
  assign opcode         = if_id_instr[31:21];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory responder with programmable latency, transaction-level model, literal spot checks.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_id_valid;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [10:0] opcode;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int lat = 1;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .if_id_valid(if_id_valid),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .opcode(opcode)
  );

  function automatic logic [31:0] word(input logic [63:0] a);
    if (a == 64'h0) return 32'h8B020020;
    if (a == 64'h4) return 32'h8B030041;
    return 32'hA500_0000 ^ a[31:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Instruction memory: single outstanding request, response after 'lat' cycles, reset with the DUT.
  int          mem_cnt = 0;
  logic [63:0] mem_a = '0;
  always begin
    @(negedge clk);
    if (!rst_n) mem_cnt = 0;
    else if (imem_req_valid && imem_req_ready) begin
      mem_cnt = lat;
      mem_a   = imem_addr;
    end
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word(mem_a);
      end
    end
  end

  // Model: a fetch is either idle (may issue), in flight, or parked waiting for decode.
  logic [63:0] m_pc, m_ipc, m_pp, dp;
  logic [31:0] m_instr, m_pw, dw;
  bit          m_out, m_drop, m_pend, m_vld, dlv;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = 64'h0; m_out = 0; m_drop = 0; m_pend = 0;
      m_vld = 0; m_ipc = 64'h0; m_instr = 32'h0;
    end else if (redirect_valid) begin
      if (!m_out && !m_pend) begin
        if (imem_req_ready) begin m_out = 1; m_drop = 1; end
      end else if (m_out) begin
        if (imem_rsp_valid) begin m_out = 0; m_drop = 0; end
        else m_drop = 1;
      end
      m_pend = 0;
      m_vld  = 0;
      m_pc   = redirect_pc & ~64'd3;
    end else begin
      dlv = 0; dw = 32'h0; dp = 64'h0;
      if (!m_out && !m_pend) begin
        if (imem_req_ready) m_out = 1;
      end else if (m_out) begin
        if (imem_rsp_valid) begin
          m_out = 0;
          if (m_drop) m_drop = 0;
          else if (m_vld && stall) begin m_pend = 1; m_pw = imem_rsp_data; m_pp = m_pc; end
          else begin dlv = 1; dw = imem_rsp_data; dp = m_pc; m_pc = m_pc + 64'd4; end
        end
      end else if (!stall) begin
        dlv = 1; dw = m_pw; dp = m_pp; m_pend = 0; m_pc = m_pc + 64'd4;
      end
      if (dlv) begin m_vld = 1; m_ipc = dp; m_instr = dw; end
      else if (!stall) m_vld = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_req_valid", imem_req_valid, rst_n && !m_out && !m_pend);
      if (rst_n && !m_out && !m_pend) chk("m_addr", imem_addr, m_pc);
      chk("m_if_id_valid", if_id_valid, m_vld);
      chk("m_if_id_pc", if_id_pc, m_ipc);
      chk("m_if_id_instr", if_id_instr, m_instr);
      chk("m_opcode", opcode, m_instr[31:21]);
    end
  end

  task automatic nxt(); @(posedge clk); #2; endtask
  task automatic smp(); @(negedge clk); endtask

  initial begin
    rst_n = 0; stall = 0; redirect_valid = 0; redirect_pc = '0; imem_req_ready = 1;
    nxt(); chk_en = 1;
    smp();
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_if_id_valid", if_id_valid, 0);
    chk("rst_opcode", opcode, 0);
    nxt(); nxt();
    rst_n = 1; smp();
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_addr", imem_addr, 64'h0);
    nxt(); smp(); chk("r1_valid", if_id_valid, 0);
    nxt(); smp();
    chk("pc0_valid", if_id_valid, 1);
    chk("pc0_pc", if_id_pc, 64'h0);
    chk("pc0_instr", if_id_instr, 32'h8B020020);
    chk("pc0_opcode", opcode, 11'h458);
    nxt(); smp(); chk("r3_bubble", if_id_valid, 0);
    nxt(); imem_req_ready = 0; smp();
    chk("pc4_valid", if_id_valid, 1);
    chk("pc4_pc", if_id_pc, 64'h4);
    chk("pc4_opcode", opcode, 11'h458);
    chk("nordy_addr0", imem_addr, 64'h8);
    for (int i = 0; i < 2; i++) begin
      nxt(); smp();
      chk("nordy_req_valid", imem_req_valid, 1);
      chk("nordy_addr", imem_addr, 64'h8);
      chk("nordy_no_valid", if_id_valid, 0);
    end
    nxt(); imem_req_ready = 1; smp(); chk("rdy_addr", imem_addr, 64'h8);
    nxt(); smp(); chk("wait_no_req", imem_req_valid, 0);
    nxt(); stall = 1; smp();
    chk("pc8_pc", if_id_pc, 64'h8);
    chk("req_c_addr", imem_addr, 64'hC);
    nxt(); smp(); chk("stall_hold_pc", if_id_pc, 64'h8);
    nxt(); stall = 0; lat = 3; smp();
    chk("hold_no_req", imem_req_valid, 0);
    chk("hold_keep_valid", if_id_valid, 1);
    chk("hold_keep_pc", if_id_pc, 64'h8);
    nxt(); smp();
    chk("skid_pc", if_id_pc, 64'hC);
    chk("skid_valid", if_id_valid, 1);
    chk("req_10_addr", imem_addr, 64'h10);
    nxt(); redirect_valid = 1; redirect_pc = 64'h103; lat = 1; smp();
    nxt(); redirect_valid = 0; smp(); chk("drop_wait_no_req", imem_req_valid, 0);
    nxt(); smp(); chk("drop_rsp_no_req", imem_req_valid, 0);
    nxt(); smp();
    chk("target_addr", imem_addr, 64'h100);
    chk("target_no_valid", if_id_valid, 0);
    nxt(); smp();
    nxt(); stall = 1; smp();
    chk("target_pc", if_id_pc, 64'h100);
    chk("target_instr", if_id_instr, 32'hA500_0100);
    nxt(); redirect_valid = 1; redirect_pc = 64'h200; smp();
    chk("stall_held_pc", if_id_pc, 64'h100);
    nxt(); redirect_valid = 0; stall = 0; smp();
    chk("flush_valid", if_id_valid, 0);
    chk("flush_addr", imem_addr, 64'h200);
    nxt(); nxt(); smp(); chk("pc200", if_id_pc, 64'h200);
    nxt(); rst_n = 0; smp(); chk("midrst_req_valid", imem_req_valid, 0);
    nxt(); smp();
    chk("midrst_valid", if_id_valid, 0);
    chk("midrst_pc", if_id_pc, 64'h0);
    chk("midrst_instr", if_id_instr, 32'h0);
    nxt(); rst_n = 1; redirect_valid = 1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE; smp();
    chk("postrst_addr", imem_addr, 64'h0);
    nxt(); redirect_valid = 0; smp();
    nxt(); smp(); chk("wrap_req_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    nxt(); nxt(); smp();
    chk("wrap_if_pc", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_next_addr", imem_addr, 64'h0);
    for (int i = 0; i < 80; i++) begin
      nxt();
      stall          = ($urandom_range(0, 3) == 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      lat            = $urandom_range(1, 3);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = {32'h0, $urandom};
    end
    nxt(); redirect_valid = 0; stall = 0; imem_req_ready = 1;
    repeat (8) nxt();
    smp();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
